// File: rtl/hello_pkg.sv
// Shared constants and types for the "Hello, World!" UART transmitter.
package hello_pkg;

    localparam int MSG_LEN = 14;
    localparam int IDX_W   = 4;

    // Message bytes in transmission order: "Hello, World!" followed by LF.
    localparam logic [7:0] MSG [MSG_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
        8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A
    };

    // Top-level sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hello_uart_tx.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit,
// each held CLK_DIV cycles. The start bit goes out on the accepting edge.
module hello_uart_tx #(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic             active_reg;
    logic [3:0]       bit_idx_reg;   // 0 = start, 1..8 = data, 9 = stop
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       data_reg;
    logic             txd_reg;

    logic bit_end;
    logic frame_end;
    logic accept;

    assign bit_end   = (cnt_reg == CNT_MAX);
    assign frame_end = active_reg && bit_end && (bit_idx_reg == 4'd9);

    // Ready is already high during the last stop-bit cycle so the sequencer
    // can present the next byte in the single idle cycle between frames.
    assign tx_ready = !active_reg || frame_end;
    assign accept   = tx_valid && tx_ready;
    assign txd      = txd_reg;

    // Bit timing, shift sequencing and line driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg  <= 1'b0;
            bit_idx_reg <= 4'd0;
            cnt_reg     <= '0;
            data_reg    <= 8'd0;
            txd_reg     <= 1'b1;
        end else if (accept) begin
            active_reg  <= 1'b1;
            bit_idx_reg <= 4'd0;
            cnt_reg     <= '0;
            data_reg    <= tx_data;
            txd_reg     <= 1'b0;
        end else if (active_reg) begin
            if (bit_end) begin
                cnt_reg <= '0;
                if (bit_idx_reg == 4'd9) begin
                    active_reg <= 1'b0;
                    txd_reg    <= 1'b1;
                end else begin
                    bit_idx_reg <= bit_idx_reg + 4'd1;
                    // Next bit is data[bit_idx] for 0..7, stop bit after data[7].
                    txd_reg <= (bit_idx_reg == 4'd8) ? 1'b1 : data_reg[bit_idx_reg[2:0]];
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hello_uart.sv
// Sends the fixed "Hello, World!\n" message over a UART line on request.
module hello_uart #(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       txd,
    output logic [3:0] char_idx
);

    import hello_pkg::*;

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("hello_uart: CLK_DIV must be at least 2");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             start_q_reg;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;

    // State, index and start-sample registers. Start is only captured while
    // idle, so a request held through DONE begins anew from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            start_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            start_q_reg <= start && (state_reg == IDLE);
        end
    end

    // Next-state and message index sequencing.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        unique case (state_reg)
            IDLE: begin
                if (start_q_reg) state_next = LOAD;
            end
            LOAD: begin
                if (tx_ready) state_next = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_reg < LAST_IDX) begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                idx_next   = '0;
                state_next = IDLE;
            end
            default: begin
                idx_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs and byte presentation to the serializer.
    always_comb begin
        tx_valid = (state_reg == LOAD);
        busy     = (state_reg == LOAD) || (state_reg == SEND);
        done     = (state_reg == DONE);
        tx_data  = MSG[idx_reg];
        char_idx = idx_reg;
    end

    hello_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .txd      (txd)
    );

endmodule

// File: tb/tb_hello_uart.sv
// Directed/randomized bench for hello_uart with a line-level UART monitor.
module tb_hello_uart;

    localparam int D     = 4;
    localparam int FRAME = 10 * D;
    localparam int LAT   = 140 * D + 15;

    string MSG_S = "Hello, World!\n";

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       txd;
    logic [3:0] char_idx;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    byte unsigned rx_q[$];
    int           fall_q[$];
    int           done_q[$];
    int           frame_err = 0;

    hello_uart #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .txd      (txd),
        .char_idx (char_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver model: samples each bit in its middle, records frame
    // start cycles, decoded bytes and done pulses.
    bit         rx_active = 1'b0;
    int         rx_fall   = 0;
    logic [7:0] rx_byte   = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (txd === 1'b0) begin
                rx_active = 1'b1;
                rx_fall   = cyc;
                fall_q.push_back(cyc);
            end
        end else begin
            int off;
            off = cyc - rx_fall;
            if (off % D == D / 2) begin
                if (off / D == 0) begin
                    if (txd !== 1'b0) frame_err++;
                end else if (off / D <= 8) begin
                    rx_byte[off / D - 1] = txd;
                end else begin
                    if (txd !== 1'b1) frame_err++;
                    rx_q.push_back(rx_byte);
                    rx_active = 1'b0;
                    $display("rx byte 0x%02h '%s' frame_start=%0d", rx_byte, string'(rx_byte), rx_fall);
                end
            end
        end
        if (rst_n && done === 1'b1) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rx_at(input int i);
        return (i < rx_q.size()) ? int'(rx_q[i]) : -1;
    endfunction

    function automatic int fall_at(input int i);
        return (i < fall_q.size()) ? fall_q[i] : -1;
    endfunction

    task automatic clear_q();
        rx_q.delete();
        fall_q.delete();
        done_q.delete();
    endtask

    // Single-cycle start pulse; returns the cycle of the sampling edge.
    task automatic pulse_start(output int s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
    endtask

    // Waits (bounded) for done; tallies busy-low cycles and index drops.
    task automatic wait_done(input int budget, input int busy_from,
                             output int dcyc, output int busy_bad, output int idx_drop);
        logic [3:0] last_idx;
        last_idx = char_idx;
        dcyc     = -1;
        busy_bad = 0;
        idx_drop = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (cyc >= busy_from && busy !== 1'b1) busy_bad++;
            if (char_idx < last_idx) idx_drop++;
            last_idx = char_idx;
        end
    endtask

    task automatic check_msg(input string tag, input int base);
        for (int i = 0; i < 14; i++)
            check($sformatf("%s_byte%0d", tag, i), rx_at(base + i), int'(MSG_S[i]));
    endtask

    initial begin
        int s, d1, d2, bb, idd, n;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", char_idx, 0);
        rst_n = 1'b1;

        // T1: single pulse, full message
        repeat ($urandom_range(2, 9)) @(negedge clk);
        clear_q();
        pulse_start(s);
        wait_done(LAT + 50, s + 1, d1, bb, idd);
        check("t1_done_cyc", d1, s + LAT);
        check("t1_busy_low", bb, 0);
        check("t1_idx_drop", idd, 0);
        repeat (3) @(negedge clk);
        check("t1_first_fall", fall_at(0), s + 2);
        check("t1_nbytes", rx_q.size(), 14);
        check_msg("t1", 0);
        for (int i = 1; i < 14; i++)
            check($sformatf("t1_gap%0d", i), fall_at(i) - fall_at(i - 1), FRAME + 1);
        check("t1_done_pulses", done_q.size(), 1);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_idx", char_idx, 0);
        $display("message 1 done at +%0d cycles", d1 - s);

        // T2: start held high across two messages
        repeat ($urandom_range(1, 7)) @(negedge clk);
        clear_q();
        start = 1'b1;
        s = cyc + 1;
        wait_done(LAT + 50, s + 1, d1, bb, idd);
        check("t2_done1_cyc", d1, s + LAT);
        wait_done(LAT + 50, d1 + 3, d2, bb, idd);
        check("t2_done2_cyc", d2, d1 + 2 + LAT);
        check("t2_busy_low", bb, 0);
        start = 1'b0;
        repeat (60) @(negedge clk);
        check("t2_nbytes", rx_q.size(), 28);
        check_msg("t2a", 0);
        check_msg("t2b", 14);
        check("t2_done_pulses", done_q.size(), 2);
        check("t2_frames", fall_q.size(), 28);
        check("t2_idle_busy", busy, 0);
        $display("held-start messages done at +%0d and +%0d", d1 - s, d2 - s);

        // T3: stray start during byte 5 is ignored
        clear_q();
        pulse_start(s);
        n = 0;
        while (char_idx !== 4'd5 && n < 2 * LAT) begin
            @(negedge clk);
            n++;
        end
        check("t3_reach_idx5", char_idx, 5);
        repeat ($urandom_range(1, 30)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(LAT + 50, 0, d1, bb, idd);
        check("t3_done_cyc", d1, s + LAT);
        check("t3_busy_low", bb, 0);
        check("t3_idx_drop", idd, 0);
        repeat (60) @(negedge clk);
        check("t3_nbytes", rx_q.size(), 14);
        check_msg("t3", 0);
        check("t3_done_pulses", done_q.size(), 1);
        $display("stray-start message done at +%0d", d1 - s);

        // T4: reset in the middle of byte 3, then restart from 'H'
        clear_q();
        pulse_start(s);
        n = 0;
        while (char_idx !== 4'd3 && n < 2 * LAT) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_idx3", char_idx, 3);
        repeat ($urandom_range(5, 35)) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t4_rst_txd", txd, 1);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_idx", char_idx, 0);
        check("t4_rst_done", done, 0);
        repeat (2) @(negedge clk);
        check("t4_partial_bytes", rx_q.size(), 3);
        rst_n = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        clear_q();
        pulse_start(s);
        wait_done(LAT + 50, s + 1, d1, bb, idd);
        check("t4_done_cyc", d1, s + LAT);
        repeat (3) @(negedge clk);
        check("t4_first_fall", fall_at(0), s + 2);
        check("t4_nbytes", rx_q.size(), 14);
        check_msg("t4", 0);
        check("t4_frame_err", frame_err, 0);
        $display("post-reset message done at +%0d", d1 - s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hello_uart.md
HELLO_UART -- requirements
Module: hello_uart

Interface
REQ-001 The block SHALL have one parameter: CLK_DIV, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset; clk and rst_n are listed first below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to transmit the message; sampled on rising clk edges.
REQ-006 busy  output  1  high while a message transmission is in progress.
REQ-007 done  output  1  one-cycle pulse after the final stop bit of the message completes.
REQ-008 txd  output  1  UART serial line, 8N1, idle high.
REQ-009 char_idx  output  4  index (0..13) of the byte currently being sent; 0 when idle.

Function
REQ-010 The message SHALL be the 14 bytes "Hello, World!" followed by 0x0A, sent in order from index 0 to 13.
REQ-011 The top FSM SHALL have states IDLE, LOAD, SEND and DONE.
REQ-012 IDLE: start=1 moves to LOAD; start in LOAD, SEND or DONE SHALL be ignored, with no queuing.
REQ-013 LOAD: presents message[char_idx] to the serializer with tx_valid=1; on tx_valid&tx_ready it moves to SEND.
REQ-014 SEND: waits for tx_ready; it then increments char_idx and returns to LOAD if char_idx<13, else moves to DONE.
REQ-015 DONE: asserts done for exactly one cycle, clears char_idx, and returns to IDLE.
REQ-016 busy SHALL be 1 in LOAD and SEND and 0 in IDLE and DONE.
REQ-017 The serializer SHALL accept a byte only when tx_valid&tx_ready, deasserting tx_ready the following cycle.
REQ-018 The frame SHALL be: start bit 0, eight data bits LSB first, stop bit 1, each held exactly CLK_DIV cycles (10*CLK_DIV cycles per frame).
REQ-019 txd SHALL fall on the 2nd rising clk edge after the edge that samples start=1 in IDLE.
REQ-020 Between consecutive frames, txd SHALL be 1 for exactly 1 clk cycle (the handshake cycle).
REQ-021 The serializer SHALL reassert tx_ready in the cycle after the stop bit's last cycle.
REQ-022 The bit-period counter width SHALL be $clog2(CLK_DIV); it counts 0..CLK_DIV-1 and wraps.
REQ-023 done SHALL rise the cycle after the final stop bit ends; start-to-done latency SHALL be 140*CLK_DIV+15 cycles.
REQ-024 A start value held high across DONE SHALL begin a new message only once the FSM is back in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force txd=1, busy=0, done=0, char_idx=0, FSM=IDLE, serializer idle with tx_ready=1 and counters 0.
REQ-026 Reset asserted mid-frame SHALL abort the message, with no partial byte completion.
REQ-027 After reset deassertion, the first start SHALL transmit from index 0.

Structure
REQ-028 Package hello_pkg SHALL hold MSG_LEN=14, the constant message byte array, and the top FSM state enum.
REQ-029 Serialization SHALL reside in sub-module hello_uart_tx, with ports clk, rst_n, tx_valid, tx_data[7:0], tx_ready and txd.
REQ-030 An elaboration-time check SHALL reject CLK_DIV<2.

Verification (CLK_DIV=4 unless stated)
REQ-031 Single start pulse -> txd falls 2 cycles later; first frame decodes as 0x48 (data bits 0,0,0,1,0,0,1,0 LSB first, each 4 cycles).
REQ-032 Full message -> bench UART monitor receives "Hello, World!\n" (14 bytes); done pulses once at cycle 575 after start; busy high throughout.
REQ-033 start held high continuously -> messages repeat; done pulses once per message; no bytes are dropped or duplicated.
REQ-034 start pulsed during byte 5 -> ignored; exactly 14 bytes are sent and char_idx never resets early.
REQ-035 rst_n asserted mid-frame of byte 3 -> txd=1 within the same cycle, busy=0; the next start sends from 'H'.
REQ-036 CLK_DIV=868 -> each bit is 868 cycles and inter-frame high time is 1 cycle; done arrives 121535 cycles after start.
